i2c_slave: RTL and testbench

- I2C target (slave) block: single 8-bit data register reachable over a two-wire bus (SDA open-drain, SCL input).
- Oversamples SCL/SDA with the system clock; decodes START/STOP, 7-bit address and R/W bit.
- ACKs its own address, accepts write bytes into the register, returns the register on reads.
- Sits at the chip pad boundary; the register value is exported to core logic.

---
 rtl/i2c_slave_pkg.sv | 22 ++
 rtl/i2c_bus_sync.sv | 50 +++++
 rtl/i2c_slave.sv | 205 ++++++++++++++++++++
 tb/tb_i2c_slave.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/i2c_slave_pkg.sv
// Shared definitions for the I2C target block.
//   state_t  : protocol FSM states
//   RW_*     : encoding of the R/W bit that follows the 7-bit address
//   BYTE_W   : bits per bus byte (excluding the ACK slot)
package i2c_slave_pkg;

  localparam int BYTE_W = 8;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WRITE,
    ST_DATA_ACK,
    ST_READ,
    ST_READ_ACK
  } state_t;

endpackage

// File: rtl/i2c_bus_sync.sv
// Input conditioning for the I2C pins.
// Each pin goes through two synchronizer flops plus a third "previous" flop
// used for edge detection. All outputs are derived from synchronized values.
//   clk, rst_n          : system clock, async active-low reset
//   scl_in, sda_in      : raw bus pins
//   sda_s               : synchronized SDA level
//   scl_rise, scl_fall  : one-clk pulses on synchronized SCL edges
//   start_det, stop_det : one-clk pulses for START / STOP bus conditions
module i2c_bus_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  // [0] first sync stage, [1] synchronized value, [2] previous synchronized value
  logic [2:0] scl_q, scl_d;
  logic [2:0] sda_q, sda_d;

  always_comb begin
    scl_d = {scl_q[1:0], scl_in};
    sda_d = {sda_q[1:0], sda_in};
  end

  // Reset to the idle-bus level so leaving reset never looks like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else begin
      scl_q <= scl_d;
      sda_q <= sda_d;
    end
  end

  assign sda_s    = sda_q[1];
  assign scl_rise =  scl_q[1] & ~scl_q[2];
  assign scl_fall = ~scl_q[1] &  scl_q[2];

  // SCL must be high in both samples so an SDA change coincident with an
  // SCL edge is not mistaken for a bus condition.
  assign start_det = scl_q[1] & scl_q[2] &  sda_q[2] & ~sda_q[1];
  assign stop_det  = scl_q[1] & scl_q[2] & ~sda_q[2] &  sda_q[1];

endmodule

// File: rtl/i2c_slave.sv
// I2C target with a single 8-bit data register.
//   clk, rst_n : system clock (>= 8x SCL), async active-low reset
//   SCL        : bus clock input (never driven)
//   SDA        : open-drain bus data, driven only to 0 or released (Z)
//   data_out   : current data register contents
//   data_valid : one-clk pulse when a written byte is committed
//   busy       : high from own-address ACK until STOP or repeated START
module i2c_slave
  import i2c_slave_pkg::*;
#(
  parameter logic [6:0] ADDR = 7'h08
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       SCL,
  inout  wire        SDA,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       busy
);

  localparam logic [3:0] LAST_BIT = 4'(BYTE_W - 1);
  localparam logic [3:0] BYTE_CNT = 4'(BYTE_W);

  logic sda_s, scl_rise, scl_fall, start_det, stop_det;

  i2c_bus_sync u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl_in    (SCL),
    .sda_in    (SDA),
    .sda_s     (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  state_t      state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [6:0]  shift_q, shift_d;     // 7 bits held; the 8th is taken live from sda_s
  logic [7:0]  tx_q, tx_d;
  logic [7:0]  data_q, data_d;
  logic        rw_q, rw_d;
  logic        ack_pend_q, ack_pend_d; // ACK owed on the next scl_fall
  logic        sda_oe_q, sda_oe_d;     // 1 = pull SDA low
  logic        dv_q, dv_d;
  logic        busy_q, busy_d;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    data_d     = data_q;
    rw_d       = rw_q;
    ack_pend_d = ack_pend_q;
    sda_oe_d   = sda_oe_q;
    dv_d       = 1'b0;
    busy_d     = busy_q;

    // Bus conditions override any bit activity in the same cycle.
    if (stop_det) begin
      state_d    = ST_IDLE;
      bit_cnt_d  = '0;
      ack_pend_d = 1'b0;
      sda_oe_d   = 1'b0;
      busy_d     = 1'b0;
    end else if (start_det) begin
      state_d    = ST_ADDR;
      bit_cnt_d  = '0;
      shift_d    = '0;
      ack_pend_d = 1'b0;
      sda_oe_d   = 1'b0;
      busy_d     = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: ;

        ST_ADDR: begin
          if (scl_rise) begin
            shift_d   = {shift_q[5:0], sda_s};
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == LAST_BIT) begin
              // shift_q holds the 7 address bits; sda_s is R/W.
              if (shift_q == ADDR) begin
                ack_pend_d = 1'b1;
                rw_d       = sda_s;
              end else begin
                state_d  = ST_IDLE;
                sda_oe_d = 1'b0;
              end
            end
          end else if (scl_fall && ack_pend_q) begin
            ack_pend_d = 1'b0;
            sda_oe_d   = 1'b1;
            busy_d     = 1'b1;
            state_d    = ST_ADDR_ACK;
          end
        end

        ST_ADDR_ACK: begin
          if (scl_fall) begin
            if (rw_q == RW_READ) begin
              // First data bit goes out on the same fall that ends the ACK.
              state_d   = ST_READ;
              sda_oe_d  = ~data_q[7];
              tx_d      = {data_q[6:0], 1'b0};
              bit_cnt_d = 4'd1;
            end else begin
              state_d   = ST_WRITE;
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
            end
          end
        end

        ST_WRITE: begin
          if (scl_rise) begin
            shift_d   = {shift_q[5:0], sda_s};
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == LAST_BIT) begin
              data_d     = {shift_q, sda_s};
              dv_d       = 1'b1;
              ack_pend_d = 1'b1;
            end
          end else if (scl_fall && ack_pend_q) begin
            ack_pend_d = 1'b0;
            sda_oe_d   = 1'b1;
            state_d    = ST_DATA_ACK;
          end
        end

        ST_DATA_ACK: begin
          if (scl_fall) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = '0;
            state_d   = ST_WRITE;
          end
        end

        ST_READ: begin
          // bit_cnt counts bits already placed on the bus.
          if (scl_fall) begin
            if (bit_cnt_q == BYTE_CNT) begin
              sda_oe_d = 1'b0;
              state_d  = ST_READ_ACK;
            end else begin
              sda_oe_d  = ~tx_q[7];
              tx_d      = {tx_q[6:0], 1'b0};
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end

        ST_READ_ACK: begin
          if (scl_rise) begin
            if (sda_s) state_d = ST_IDLE;   // NACK: stay off the bus until STOP/START
            else       ack_pend_d = 1'b1;
          end else if (scl_fall && ack_pend_q) begin
            ack_pend_d = 1'b0;
            state_d    = ST_READ;
            sda_oe_d   = ~data_q[7];
            tx_d       = {data_q[6:0], 1'b0};
            bit_cnt_d  = 4'd1;
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      tx_q       <= '0;
      data_q     <= '0;
      rw_q       <= 1'b0;
      ack_pend_q <= 1'b0;
      sda_oe_q   <= 1'b0;
      dv_q       <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      data_q     <= data_d;
      rw_q       <= rw_d;
      ack_pend_q <= ack_pend_d;
      sda_oe_q   <= sda_oe_d;
      dv_q       <= dv_d;
      busy_q     <= busy_d;
    end
  end

  assign SDA        = sda_oe_q ? 1'b0 : 1'bz;
  assign data_out   = data_q;
  assign data_valid = dv_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_i2c_slave.sv
module tb_i2c_slave;

  localparam int Q = 10;  // quarter SCL period in clk cycles

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic scl   = 1'b1;
  logic m_low = 1'b0;     // master pulling SDA low
  wire  sda_w;

  logic [7:0] data_out;
  logic       data_valid;
  logic       busy;

  assign sda_w = m_low ? 1'b0 : 1'bz;
  pullup (sda_w);

  always #5 clk = ~clk;

  i2c_slave #(.ADDR(7'h08)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .SCL        (scl),
    .SDA        (sda_w),
    .data_out   (data_out),
    .data_valid (data_valid),
    .busy       (busy)
  );

  int checks = 0;
  int errors = 0;
  int dv_pulses = 0;
  int exp_pulses = 0;
  logic [7:0] exp_q[$];
  logic [7:0] model_reg = 8'h00;
  logic [7:0] sb_val;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Scoreboard: every committed byte must match the next expected write.
  always @(negedge clk) begin
    if (rst_n && data_valid) begin
      dv_pulses++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dv_unexpected: data_valid with data_out %h, none expected", data_out);
      end else begin
        sb_val = exp_q.pop_front();
        check("dv_data", data_out, sb_val);
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic q_wait();
    repeat (Q) @(negedge clk);
  endtask

  task automatic bit_xfer(input logic b, output logic s);
    q_wait(); m_low = ~b;
    q_wait(); scl = 1'b1;
    q_wait(); s = sda_w;
    q_wait(); scl = 1'b0;
  endtask

  task automatic start_cond();
    q_wait(); m_low = 1'b0;
    q_wait(); scl = 1'b1;
    q_wait(); m_low = 1'b1;
    q_wait(); scl = 1'b0;
  endtask

  task automatic stop_cond();
    q_wait(); m_low = 1'b1;
    q_wait(); scl = 1'b1;
    q_wait(); m_low = 1'b0;
    q_wait();
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_xfer(b[i], s);
    bit_xfer(1'b1, s);
    ack = ~s;
  endtask

  task automatic read_byte(input logic m_ack, output logic [7:0] d, output logic ack_slot);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, s);
      d[i] = s;
    end
    bit_xfer(~m_ack, ack_slot);
  endtask

  task automatic write_txn(input logic [7:0] addr_rw, input logic [7:0] wdata, input logic exp_ack);
    logic a;
    start_cond();
    write_byte(addr_rw, a);
    check("addr_ack", {7'd0, a}, {7'd0, exp_ack});
    check("busy_after_addr", {7'd0, busy}, {7'd0, exp_ack});
    if (exp_ack) begin
      model_reg = wdata;
      exp_q.push_back(wdata);
      exp_pulses++;
    end
    write_byte(wdata, a);
    check("data_ack", {7'd0, a}, {7'd0, exp_ack});
    stop_cond();
    check("data_out", data_out, model_reg);
    check("busy_after_stop", {7'd0, busy}, 8'd0);
  endtask

  typedef struct {
    logic [7:0] addr_rw;
    logic [7:0] wdata;
    logic       exp_ack;
  } wvec_t;

  wvec_t vecs[4];

  initial begin
    logic a, slot, s;
    logic [7:0] d;

    vecs[0] = '{addr_rw: 8'h12, wdata: 8'hFF, exp_ack: 1'b0};  // 7'h09 W: not us
    vecs[1] = '{addr_rw: 8'h10, wdata: 8'h3C, exp_ack: 1'b1};
    vecs[2] = '{addr_rw: 8'h20, wdata: 8'h00, exp_ack: 1'b0};  // 7'h10 W: not us
    vecs[3] = '{addr_rw: 8'h10, wdata: 8'h67, exp_ack: 1'b1};

    // 1: reset and idle bus
    repeat (5) @(negedge clk);
    check("rst_data_out", data_out, 8'h00);
    check("rst_busy", {7'd0, busy}, 8'd0);
    check("rst_sda", {7'd0, sda_w}, 8'd1);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    check("idle_data_out", data_out, 8'h00);
    check("idle_sda", {7'd0, sda_w}, 8'd1);
    check("idle_dv_pulses", 8'(dv_pulses), 8'd0);

    // 2 and 4: table of write transactions
    for (int i = 0; i < 4; i++) write_txn(vecs[i].addr_rw, vecs[i].wdata, vecs[i].exp_ack);

    // 3: read back with master NACK
    start_cond();
    write_byte(8'h11, a);
    check("rd_addr_ack", {7'd0, a}, 8'd1);
    read_byte(1'b0, d, slot);
    check("rd_data", d, model_reg);
    check("rd_released_after_8", {7'd0, slot}, 8'd1);
    stop_cond();
    check("rd_busy_after_stop", {7'd0, busy}, 8'd0);

    // 5: write A5, abort a second byte with repeated START, read twice
    write_txn(8'h10, 8'hA5, 1'b1);
    start_cond();
    write_byte(8'h10, a);
    check("abort_addr_ack", {7'd0, a}, 8'd1);
    for (int i = 0; i < 4; i++) bit_xfer(1'b0, s);
    start_cond();
    check("abort_busy_cleared", {7'd0, busy}, 8'd0);
    write_byte(8'h11, a);
    check("rs_addr_ack", {7'd0, a}, 8'd1);
    read_byte(1'b1, d, slot);
    check("rs_rd_data0", d, model_reg);
    read_byte(1'b0, d, slot);
    check("rs_rd_data1", d, model_reg);
    stop_cond();
    check("abort_data_out", data_out, 8'hA5);

    // 6: reset while ACK is held across SCL high
    start_cond();
    for (int i = 7; i >= 0; i--) bit_xfer(i == 4 ? 1'b1 : 1'b0, s);
    q_wait(); m_low = 1'b0;
    q_wait(); scl = 1'b1;
    q_wait();
    check("ack_held", {7'd0, sda_w}, 8'd0);
    check("ack_busy", {7'd0, busy}, 8'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_sda", {7'd0, sda_w}, 8'd1);
    check("async_rst_busy", {7'd0, busy}, 8'd0);
    check("async_rst_data", data_out, 8'h00);
    model_reg = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    write_txn(8'h10, 8'h5A, 1'b1);

    repeat (10) @(negedge clk);
    check("sb_empty", 8'(exp_q.size()), 8'd0);
    check("dv_pulse_count", 8'(dv_pulses), 8'(exp_pulses));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
